// File: rtl/ysyx_pkg.sv
// Shared sizing, tag encoding and reorder-buffer entry layout for the ysyx core.
`ifndef YSYX_ROB_SIZE
`define YSYX_ROB_SIZE 8
`endif
`ifndef YSYX_XLEN
`define YSYX_XLEN 32
`endif

package ysyx_pkg;
  localparam int ROB_SIZE = `YSYX_ROB_SIZE;
  localparam int XLEN     = `YSYX_XLEN;
  localparam int PW       = $clog2(ROB_SIZE);
  localparam int TW       = PW + 1;
  localparam logic [TW-1:0] TAG_NONE = '0;

  typedef struct packed {
    logic            busy;
    logic            done;
    logic [4:0]      rd;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pnpc;
    logic [XLEN-1:0] result;
    logic [XLEN-1:0] npc;
    logic            br;
    logic            sys;
  } rob_entry_t;

  // Entry i owns tag i+1 so that tag 0 can mean "no producer".
  function automatic logic [TW-1:0] idx_to_tag(input logic [PW-1:0] idx);
    return TW'(idx) + TW'(1);
  endfunction
endpackage

// File: rtl/exu_pipe_if.sv
// EXU -> ROB writeback bundle.
interface exu_pipe_if;
  import ysyx_pkg::*;
  logic            valid;
  logic [TW-1:0]   dest;
  logic [XLEN-1:0] result;
  logic [XLEN-1:0] npc;
  logic            br_retire;
  logic            sys_retire;

  modport in  (input  valid, dest, result, npc, br_retire, sys_retire);
  modport out (output valid, dest, result, npc, br_retire, sys_retire);
endinterface

// File: rtl/ysyx_rob_lookup.sv
// Operand tag lookup: readiness and value of a producer, forwarding a same-cycle EXU writeback.
module ysyx_rob_lookup
  import ysyx_pkg::*;
(
  input  logic [TW-1:0]     tag,
  input  logic [ROB_SIZE-1:0] done_vec,
  input  logic [XLEN-1:0]   result_arr [ROB_SIZE],
  input  logic              exu_valid,
  input  logic [TW-1:0]     exu_dest,
  input  logic [XLEN-1:0]   exu_result,
  output logic              rdy,
  output logic [XLEN-1:0]   val
);
  logic [PW-1:0] idx;
  logic          fwd;

  assign idx = PW'(tag - TW'(1));
  assign fwd = exu_valid && (exu_dest == tag);

  always_comb begin
    rdy = 1'b1;
    val = '0;
    if (tag != TAG_NONE) begin
      rdy = fwd | done_vec[idx];
      val = fwd ? exu_result : result_arr[idx];
    end
  end
endmodule

// File: rtl/ysyx_rob.sv
// Reorder buffer: allocates tags at dispatch, captures EXU results, retires in order and flushes on mispredict.
module ysyx_rob
  import ysyx_pkg::*;
(
  input  logic            clock,
  input  logic            reset,
  input  logic            dis_valid,
  output logic            dis_ready,
  input  logic [4:0]      dis_rd,
  input  logic [XLEN-1:0] dis_pc,
  input  logic [XLEN-1:0] dis_pnpc,
  output logic [TW-1:0]   dis_tag,
  input  logic [TW-1:0]   q1_tag,
  input  logic [TW-1:0]   q2_tag,
  output logic            q1_rdy,
  output logic            q2_rdy,
  output logic [XLEN-1:0] q1_val,
  output logic [XLEN-1:0] q2_val,
  exu_pipe_if.in          exu,
  output logic            cm_valid,
  output logic [4:0]      cm_rd,
  output logic [XLEN-1:0] cm_data,
  output logic [XLEN-1:0] cm_pc,
  output logic [TW-1:0]   cm_tag,
  output logic            flush,
  output logic [XLEN-1:0] flush_pc
);
  logic [PW-1:0]       head_reg;
  logic [PW-1:0]       tail_reg;
  logic [TW-1:0]       count_reg;
  rob_entry_t          ent [ROB_SIZE];
  rob_entry_t          head_ent;
  logic [ROB_SIZE-1:0] done_vec;
  logic [XLEN-1:0]     result_arr [ROB_SIZE];
  logic                dis_fire;

  assign head_ent  = ent[head_reg];
  assign cm_valid  = head_ent.busy & head_ent.done & ~reset;
  assign flush     = cm_valid & (head_ent.br | head_ent.sys) & (head_ent.npc != head_ent.pnpc);
  assign cm_rd     = head_ent.rd;
  assign cm_data   = head_ent.result;
  assign cm_pc     = head_ent.pc;
  assign cm_tag    = idx_to_tag(head_reg);
  assign flush_pc  = head_ent.npc;
  // Fullness comes from count alone, so a same-cycle commit never opens a slot.
  assign dis_ready = (count_reg < TW'(ROB_SIZE)) & ~flush;
  assign dis_tag   = idx_to_tag(tail_reg);
  assign dis_fire  = dis_valid & dis_ready;

  for (genvar gi = 0; gi < ROB_SIZE; gi++) begin : g_ent
    rob_entry_t ent_reg;
    logic       alloc;
    logic       retire;
    logic       wb_hit;

    assign alloc  = dis_fire && (tail_reg == PW'(gi));
    assign retire = cm_valid && (head_reg == PW'(gi));
    // Writebacks to an entry that is no longer busy are stale leftovers from a flush.
    assign wb_hit = exu.valid && (exu.dest == TW'(gi + 1)) && ent_reg.busy;

    always_ff @(posedge clock) begin
      if (reset) begin
        ent_reg.busy <= 1'b0;
        ent_reg.done <= 1'b0;
      end else if (flush) begin
        ent_reg.busy <= 1'b0;
      end else if (alloc) begin
        ent_reg.busy <= 1'b1;
        ent_reg.done <= 1'b0;
        ent_reg.rd   <= dis_rd;
        ent_reg.pc   <= dis_pc;
        ent_reg.pnpc <= dis_pnpc;
      end else begin
        if (retire) ent_reg.busy <= 1'b0;
        if (wb_hit) begin
          ent_reg.done   <= 1'b1;
          ent_reg.result <= exu.result;
          ent_reg.npc    <= exu.npc;
          ent_reg.br     <= exu.br_retire;
          ent_reg.sys    <= exu.sys_retire;
        end
      end
    end

    assign ent[gi]        = ent_reg;
    assign done_vec[gi]   = ent_reg.done;
    assign result_arr[gi] = ent_reg.result;
  end

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (dis_fire) tail_reg <= tail_reg + PW'(1);
      if (cm_valid) head_reg <= head_reg + PW'(1);
      case ({dis_fire, cm_valid})
        2'b10:   count_reg <= count_reg + TW'(1);
        2'b01:   count_reg <= count_reg - TW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  ysyx_rob_lookup u_q1 (
    .tag(q1_tag), .done_vec(done_vec), .result_arr(result_arr),
    .exu_valid(exu.valid), .exu_dest(exu.dest), .exu_result(exu.result),
    .rdy(q1_rdy), .val(q1_val)
  );

  ysyx_rob_lookup u_q2 (
    .tag(q2_tag), .done_vec(done_vec), .result_arr(result_arr),
    .exu_valid(exu.valid), .exu_dest(exu.dest), .exu_result(exu.result),
    .rdy(q2_rdy), .val(q2_val)
  );
endmodule

// File: tb/tb_ysyx_rob.sv
// Directed bench for ysyx_rob: in-order queue model checked every cycle plus literal expectations.
module tb_ysyx_rob;
  import ysyx_pkg::*;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic            dis_valid = 1'b0;
  logic [4:0]      dis_rd = '0;
  logic [31:0]     dis_pc = '0;
  logic [31:0]     dis_pnpc = '0;
  logic            dis_ready;
  logic [TW-1:0]   dis_tag;
  logic [TW-1:0]   q1_tag = '0;
  logic [TW-1:0]   q2_tag = '0;
  logic            q1_rdy, q2_rdy;
  logic [31:0]     q1_val, q2_val;
  logic            cm_valid;
  logic [4:0]      cm_rd;
  logic [31:0]     cm_data, cm_pc;
  logic [TW-1:0]   cm_tag;
  logic            flush;
  logic [31:0]     flush_pc;

  exu_pipe_if exu_if ();

  int nchk = 0;
  int nerr = 0;
  bit chk_en = 1'b0;

  always #5 clock = ~clock;

  ysyx_rob dut (
    .clock(clock), .reset(reset),
    .dis_valid(dis_valid), .dis_ready(dis_ready), .dis_rd(dis_rd),
    .dis_pc(dis_pc), .dis_pnpc(dis_pnpc), .dis_tag(dis_tag),
    .q1_tag(q1_tag), .q2_tag(q2_tag), .q1_rdy(q1_rdy), .q2_rdy(q2_rdy),
    .q1_val(q1_val), .q2_val(q2_val),
    .exu(exu_if),
    .cm_valid(cm_valid), .cm_rd(cm_rd), .cm_data(cm_data), .cm_pc(cm_pc),
    .cm_tag(cm_tag), .flush(flush), .flush_pc(flush_pc)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model: program-order queue of in-flight instructions
  typedef struct {
    int          tag;
    logic [4:0]  rd;
    logic [31:0] pc, pnpc, res, npc;
    bit          done, br, sys;
  } ins_t;

  ins_t        mq[$];
  int          m_next = 1;
  bit          m_done [9];
  logic [31:0] m_res  [9];

  function automatic void look(input logic [TW-1:0] t, output bit r, output logic [31:0] v);
    if (t == 0) begin
      r = 1'b1; v = 32'h0;
    end else if (exu_if.valid && exu_if.dest == t) begin
      r = 1'b1; v = exu_if.result;
    end else begin
      r = m_done[int'(t)]; v = m_res[int'(t)];
    end
  endfunction

  always @(negedge clock) begin
    bit          e_cm, e_fl, e_rdy, r;
    logic [31:0] v;
    ins_t        n;
    e_cm  = !reset && mq.size() > 0 && mq[0].done;
    e_fl  = e_cm && (mq[0].br || mq[0].sys) && (mq[0].npc != mq[0].pnpc);
    e_rdy = (mq.size() < ROB_SIZE) && !e_fl;
    if (chk_en) begin
      chk("cm_valid", 32'(cm_valid), 32'(e_cm));
      chk("flush", 32'(flush), 32'(e_fl));
      chk("dis_ready", 32'(dis_ready), 32'(e_rdy));
      chk("dis_tag", 32'(dis_tag), 32'(m_next));
      if (e_cm) begin
        chk("cm_rd", 32'(cm_rd), 32'(mq[0].rd));
        chk("cm_data", cm_data, mq[0].res);
        chk("cm_pc", cm_pc, mq[0].pc);
        chk("cm_tag", 32'(cm_tag), 32'(mq[0].tag));
        $display("commit tag=%0d rd=%0d data=%08h pc=%08h flush=%0b",
                 cm_tag, cm_rd, cm_data, cm_pc, flush);
      end
      if (e_fl) chk("flush_pc", flush_pc, mq[0].npc);
      look(q1_tag, r, v);
      chk("q1_rdy", 32'(q1_rdy), 32'(r));
      if (r) chk("q1_val", q1_val, v);
      look(q2_tag, r, v);
      chk("q2_rdy", 32'(q2_rdy), 32'(r));
      if (r) chk("q2_val", q2_val, v);
    end
    if (reset) begin
      mq.delete();
      m_next = 1;
      for (int i = 0; i < 9; i++) m_done[i] = 1'b0;
    end else if (e_fl) begin
      mq.delete();
      m_next = 1;
    end else begin
      if (exu_if.valid) begin
        for (int i = 0; i < mq.size(); i++) begin
          if (mq[i].tag == int'(exu_if.dest)) begin
            mq[i].done = 1'b1;
            mq[i].res  = exu_if.result;
            mq[i].npc  = exu_if.npc;
            mq[i].br   = exu_if.br_retire;
            mq[i].sys  = exu_if.sys_retire;
            m_done[mq[i].tag] = 1'b1;
            m_res[mq[i].tag]  = exu_if.result;
          end
        end
      end
      if (e_cm) void'(mq.pop_front());
      if (dis_valid && e_rdy) begin
        n.tag = m_next; n.rd = dis_rd; n.pc = dis_pc; n.pnpc = dis_pnpc;
        n.res = 32'h0; n.npc = 32'h0; n.done = 1'b0; n.br = 1'b0; n.sys = 1'b0;
        mq.push_back(n);
        m_done[m_next] = 1'b0;
        $display("dispatch tag=%0d rd=%0d pc=%08h", m_next, dis_rd, dis_pc);
        m_next = m_next % ROB_SIZE + 1;
      end
    end
  end

  // ---------------- stimulus
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    dis_valid = 1'b0;
    exu_if.valid = 1'b0;
  endtask

  task automatic disp(input logic [4:0] rd, input logic [31:0] pc, input logic [31:0] pnpc);
    dis_valid = 1'b1; dis_rd = rd; dis_pc = pc; dis_pnpc = pnpc;
  endtask

  task automatic wb(input int t, input logic [31:0] res, input logic [31:0] npc, input bit br);
    exu_if.valid = 1'b1; exu_if.dest = TW'(t); exu_if.result = res;
    exu_if.npc = npc; exu_if.br_retire = br; exu_if.sys_retire = 1'b0;
  endtask

  initial begin
    int pend[$];
    exu_if.valid = 1'b0; exu_if.dest = '0; exu_if.result = '0;
    exu_if.npc = '0; exu_if.br_retire = 1'b0; exu_if.sys_retire = 1'b0;
    step();
    chk_en = 1'b1;
    step();
    reset = 1'b0;
    #1;
    chk("rst dis_ready", 32'(dis_ready), 32'd1);
    chk("rst dis_tag", 32'(dis_tag), 32'd1);
    chk("rst cm_valid", 32'(cm_valid), 32'd0);
    chk("rst q1_rdy tag0", 32'(q1_rdy), 32'd1);
    chk("rst q1_val tag0", q1_val, 32'd0);

    // fill with 8 instructions, no writeback
    for (int i = 1; i <= 8; i++) begin
      disp(5'(i), 32'h80000000 + 32'(4 * (i - 1)), 32'h80000004 + 32'(4 * (i - 1)));
      #1;
      chk("fill tag", 32'(dis_tag), 32'(i));
      chk("fill ready", 32'(dis_ready), 32'd1);
      step();
    end
    idle();
    #1;
    chk("full ready", 32'(dis_ready), 32'd0);
    chk("full no commit", 32'(cm_valid), 32'd0);

    // out-of-order writeback 3,1,2 -> in-order commit 1,2,3
    wb(3, 32'h30, 32'h8000000c, 1'b0); #1;
    chk("wb3 no commit", 32'(cm_valid), 32'd0);
    step();
    wb(1, 32'h10, 32'h80000004, 1'b0); #1;
    chk("wb1 no commit yet", 32'(cm_valid), 32'd0);
    step();
    wb(2, 32'h20, 32'h80000008, 1'b0); #1;
    chk("commit1 valid", 32'(cm_valid), 32'd1);
    chk("commit1 rd", 32'(cm_rd), 32'd1);
    chk("commit1 data", cm_data, 32'h10);
    step();
    idle(); #1;
    chk("commit2 rd", 32'(cm_rd), 32'd2);
    chk("commit2 data", cm_data, 32'h20);
    step();
    #1;
    chk("commit3 rd", 32'(cm_rd), 32'd3);
    chk("commit3 data", cm_data, 32'h30);
    step();
    #1;
    chk("after commit3", 32'(cm_valid), 32'd0);

    // same-cycle forwarding on lookup
    q1_tag = 4'(5); q2_tag = 4'(6); #1;
    chk("q2 tag6 pending", 32'(q2_rdy), 32'd0);
    wb(5, 32'h0000abcd, 32'h80000014, 1'b0); q2_tag = '0; #1;
    chk("fwd q1_rdy", 32'(q1_rdy), 32'd1);
    chk("fwd q1_val", q1_val, 32'h0000abcd);
    chk("tag0 q2_rdy", 32'(q2_rdy), 32'd1);
    chk("tag0 q2_val", q2_val, 32'h0);
    step();
    idle(); #1;
    chk("stored q1_val", q1_val, 32'h0000abcd);
    q1_tag = '0;

    // drain remaining
    wb(4, 32'h40, 32'h80000010, 1'b0); step();
    wb(6, 32'h60, 32'h80000018, 1'b0); step();
    wb(7, 32'h70, 32'h8000001c, 1'b0); step();
    wb(8, 32'h80, 32'h80000020, 1'b0); step();
    idle();
    repeat (4) step();
    chk("drained cm_valid", 32'(cm_valid), 32'd0);
    chk("drained dis_tag", 32'(dis_tag), 32'd1);

    // mispredicted branch with 3 younger entries
    disp(5'd10, 32'h80000010, 32'h80000014); step();
    for (int i = 0; i < 3; i++) begin
      disp(5'(11 + i), 32'h80000014 + 32'(4 * i), 32'h80000018 + 32'(4 * i));
      step();
    end
    idle();
    wb(1, 32'h80000014, 32'h80000040, 1'b1); step();
    disp(5'd20, 32'h90000000, 32'h90000004);
    wb(2, 32'h55, 32'h80000018, 1'b0); #1;
    chk("br cm_valid", 32'(cm_valid), 32'd1);
    chk("br flush", 32'(flush), 32'd1);
    chk("br flush_pc", flush_pc, 32'h80000040);
    chk("br cm_rd", 32'(cm_rd), 32'd10);
    chk("br dis_ready", 32'(dis_ready), 32'd0);
    step();
    idle();
    wb(3, 32'h77, 32'h8000001c, 1'b0); #1;
    chk("post flush cm_valid", 32'(cm_valid), 32'd0);
    chk("post flush dis_tag", 32'(dis_tag), 32'd1);
    chk("post flush ready", 32'(dis_ready), 32'd1);
    step();
    idle(); #1;
    chk("stale wb ignored", 32'(cm_valid), 32'd0);

    // steady state: fill, then writeback oldest each cycle while dispatching
    for (int c = 0; c < 28; c++) begin
      disp(5'(c % 31 + 1), 32'h81000000 + 32'(4 * c), 32'h81000004 + 32'(4 * c));
      if (c >= 8 && pend.size() > 0) wb(pend.pop_front(), 32'(c) << 8, 32'h0, 1'b0);
      else exu_if.valid = 1'b0;
      #1;
      if (dis_ready) begin
        chk("steady tag range", 32'(dis_tag >= 1 && dis_tag <= 8), 32'd1);
        pend.push_back(int'(dis_tag));
      end
      step();
    end
    dis_valid = 1'b0;
    for (int k = 0; k < 20 && pend.size() > 0; k++) begin
      wb(pend.pop_front(), 32'h00ee0000 + 32'(k), 32'h0, 1'b0);
      step();
    end
    idle();
    repeat (4) step();
    chk("steady drained", 32'(cm_valid), 32'd0);
    chk("steady drained ready", 32'(dis_ready), 32'd1);

    // reset with 4 busy entries, head already done
    reset = 1'b1; step(); reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      disp(5'(21 + i), 32'h82000000 + 32'(4 * i), 32'h82000004 + 32'(4 * i));
      step();
    end
    idle();
    wb(1, 32'h1111, 32'h82000004, 1'b0); step();
    idle(); reset = 1'b1; #1;
    chk("reset cycle cm_valid", 32'(cm_valid), 32'd0);
    step();
    reset = 1'b0; #1;
    chk("after reset cm_valid", 32'(cm_valid), 32'd0);
    chk("after reset ready", 32'(dis_ready), 32'd1);
    chk("after reset dis_tag", 32'(dis_tag), 32'd1);
    repeat (2) step();

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
